instruction_fetch_unit: RTL
===========================

# instruction_fetch_unit

Owns the architectural PC register and fetches one instruction per request from instruction memory. It sits directly downstream of the program counter unit and consumes its registered PC+1 output, `PCNext`. It also feeds the current `PC` back to that unit. On each `fetch_start` from the control unit, it selects the next PC (sequential or branch target), runs a req/ready handshake with instruction memory with a timeout, and presents the instruction with a one-cycle valid pulse.

## Interface
- `ADDR_W`, 8, PC and instruction-memory address width
- `INSTR_W`, 16, instruction word width
- `RESET_PC`, 8'h00, PC value after reset; also the address of the first fetch
- `MAX_WAIT`, 15, maximum number of REQ cycles without `imem_ready` before a fault; 0 disables the timeout
- `clock` in 1: single clock; all state changes on the rising edge
- `reset` in 1: asynchronous, active-high
- `fetch_start` in 1: request the next fetch; sampled only in IDLE
- `PCNext` in ADDR_W: PC+1 from the program counter unit
- `branch_taken` in 1: selects `branch_target` instead of `PCNext`; sampled with `fetch_start`
- `branch_target` in ADDR_W: target address for a taken branch
- `halt` in 1: stop fetching; sampled only in IDLE
- `imem_ready` in 1: memory has returned data on `imem_data`
- `imem_data` in INSTR_W: instruction word
- `PC` out ADDR_W: current PC register; feeds the program counter unit
- `imem_addr` out ADDR_W: equal to `PC` at all times
- `imem_req` out 1: memory request, high throughout REQ
- `instr` out INSTR_W: last fetched instruction; held until the next fetch completes
- `instr_valid` out 1: one-cycle pulse in DONE
- `busy` out 1: high in REQ and DONE
- `halted` out 1: high in HALT
- `fetch_error` out 1: high in ERR

## Operation
- **States:** IDLE, REQ, DONE, HALT, ERR.
- **Internal flag `first`:** set by reset, cleared by the first accepted `fetch_start`.
- **IDLE:**
  - If `halt`=1, go to HALT. `halt` has priority over `fetch_start`.
  - Otherwise, if `fetch_start`=1, update the PC and go to REQ; the wait counter is cleared. PC selection:
    - `first`=1: PC keeps its value (the first fetch uses `RESET_PC`).
    - `branch_taken`=1: PC <= `branch_target`.
    - Otherwise: PC <= `PCNext`.
- **REQ:**
  - `imem_req`=1.
  - If `imem_ready`=1: `instr` <= `imem_data`, go to DONE.
  - Otherwise, if `MAX_WAIT`≠0 and the wait counter = `MAX_WAIT`-1: go to ERR.
  - Otherwise: the wait counter increments.
  - If `imem_ready` arrives on the same cycle the limit is reached, `imem_ready` wins.
- **DONE:** `instr_valid`=1 for exactly one cycle, then go to IDLE.
- **HALT, ERR:** terminal; left only via `reset`. `imem_req`=0 in both.
- **Ignored inputs:**
  - `fetch_start` and `halt` outside IDLE are ignored, not queued.
  - `branch_taken` is ignored when `first`=1.
- **Arithmetic:** no arithmetic in this block. PC wrap (FF->00) comes from `PCNext` unmodified. The wait counter is $clog2(MAX_WAIT+1) bits wide and never wraps.
- **`PCNext` timing:** `PCNext` lags `PC` by one cycle. The earliest next `fetch_start` sample is ≥2 cycles after a PC update, so `PCNext` is always settled when used.

## Timing
- **Reset values:** state=IDLE, `PC`=`RESET_PC`, `imem_addr`=`RESET_PC`, `first`=1, wait counter=0. `instr`=0, `instr_valid`=0, `imem_req`=0, `busy`=0, `halted`=0, `fetch_error`=0.
- **Asynchronous reset mid-operation:** `imem_req` and `instr_valid` drop immediately, with no wait for a clock edge.
- **Accept to request:** `fetch_start` is sampled at edge k. The new PC and `imem_req`=1 are visible in cycle k+1.
- **Zero-wait memory:** with `imem_ready`=1 in cycle k+1, `instr_valid`=1 in cycle k+2 and `busy` falls in cycle k+3. That is 2 cycles from accept to valid, and 3 cycles minimum per fetch.
- **W wait cycles:** `instr_valid` is delayed by W cycles.
- **Timeout:** REQ spans cycles k+1..k+`MAX_WAIT` with no `imem_ready`. ERR is entered and `fetch_error`=1 in cycle k+`MAX_WAIT`+1.

## Test plan
- **Reset, first fetch:** `RESET_PC`=8'h00, `fetch_start` pulse, `imem_ready`=1 immediately, `imem_data`=16'hA5A5. Required: `imem_addr`=00, `instr`=A5A5, `instr_valid` high for exactly one cycle, 2 cycles after accept. `branch_taken`=1 on this first fetch is ignored (`PC` stays 00).
- **Sequential and branch:** after PC=05, `PCNext`=06, `fetch_start` -> `imem_addr`=06. Next fetch with `branch_taken`=1, `branch_target`=8'h40 -> `imem_addr`=40.
- **Wait states and wrap:** PC=FF, `PCNext`=00, `imem_ready` delayed 3 cycles. Required: `PC`=00, `imem_req` high 4 cycles, `instr_valid` 5 cycles after accept.
- **Timeout:** `MAX_WAIT`=15, `imem_ready` held 0. Required: `fetch_error`=1 after 15 REQ cycles, `imem_req`=0, later `fetch_start` ignored. `imem_ready`=1 exactly on cycle 15 instead -> DONE, no error.
- **Halt:** `halt`=1 and `fetch_start`=1 together in IDLE -> HALT, `halted`=1, no request. `halt` during REQ -> fetch completes, then HALT from IDLE.
- **Async reset in REQ:** assert `reset` mid-cycle while `imem_req`=1. Required: all outputs at reset values before the next edge; next fetch uses `RESET_PC`.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: owns the PC, handshakes with instruction memory,
// and delivers one instruction per fetch_start with a valid pulse.
module instruction_fetch_unit #(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fetch_start,
  input  logic [ADDR_W-1:0]  PCNext,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  input  logic               halt,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic               imem_req,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               busy,
  output logic               halted,
  output logic               fetch_error
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT =
    CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DONE,
    S_HALT,
    S_ERR
  } state_t;

  state_t        state;
  logic          first;
  logic [CW-1:0] cnt;

  assign imem_addr = PC;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      PC          <= RESET_PC;
      first       <= 1'b1;
      cnt         <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      imem_req    <= 1'b0;
      busy        <= 1'b0;
      halted      <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (halt) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (fetch_start) begin
            // the very first fetch uses RESET_PC as-is
            if (!first) begin
              PC <= branch_taken ? branch_target : PCNext;
            end
            first    <= 1'b0;
            cnt      <= '0;
            state    <= S_REQ;
            imem_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_ready) begin
            instr       <= imem_data;
            instr_valid <= 1'b1;
            imem_req    <= 1'b0;
            state       <= S_DONE;
          end else if (MAX_WAIT != 0 && cnt == LIMIT) begin
            imem_req    <= 1'b0;
            busy        <= 1'b0;
            fetch_error <= 1'b1;
            state       <= S_ERR;
          end else if (cnt != '1) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
